// File: rtl/prog_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader_pkg
// Description : Shared loader/CPU constants: instruction-memory geometry and
//               the loader state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package prog_loader_pkg;

  localparam int ADDR_W    = 10;    // instruction-memory word-address width
  localparam int MAX_WORDS = 1024;  // largest accepted program length (words)

  typedef enum logic [2:0] {
    LEN_HI  = 3'd0,
    LEN_LO  = 3'd1,
    DATA_HI = 3'd2,
    DATA_LO = 3'd3,
    CHK     = 3'd4,
    DONE    = 3'd5,
    ERROR   = 3'd6
  } state_t;

  // States in which the loader is willing to take a byte
  function automatic logic accepts_bytes(input state_t s);
    return (s == LEN_HI) || (s == LEN_LO) || (s == DATA_HI) ||
           (s == DATA_LO) || (s == CHK);
  endfunction

endpackage
`default_nettype wire

// File: rtl/prog_loader_byte_pair_asm.sv
`default_nettype none
// ============================================================================
// Module      : byte_pair_asm
// Description : Latches the high byte of a big-endian pair and emits the
//               16-bit word with a one-cycle valid pulse when the low byte
//               arrives. Word output holds its value between pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_pair_asm (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        hi_en,
  input  logic        lo_en,
  input  logic [7:0]  byte_in,
  output logic [15:0] word_out,
  output logic        word_valid
);

  logic [7:0]  hi_q,    hi_d;
  logic [15:0] word_q,  word_d;
  logic        valid_q, valid_d;

  // Capture the high byte; on the low byte form the word and pulse valid
  always_comb begin
    hi_d    = hi_q;
    word_d  = word_q;
    valid_d = 1'b0;
    if (hi_en) begin
      hi_d = byte_in;
    end
    if (lo_en) begin
      word_d  = {hi_q, byte_in};
      valid_d = 1'b1;
    end
  end

  // Register state; reset also kills any pending valid pulse
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      hi_q    <= 8'h00;
      word_q  <= 16'h0000;
      valid_q <= 1'b0;
    end else begin
      hi_q    <= hi_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  assign word_out   = word_q;
  assign word_valid = valid_q;

endmodule
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader
// Description : Length-prefixed byte-stream loader for the 16-bit instruction
//               memory. Writes big-endian words to consecutive addresses and
//               raises cpu_run when the load completes.
//               Optional trailing XOR checksum byte: PROG_LOADER_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_loader
  import prog_loader_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              cpu_run,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [15:0]     MAX_LEN = 16'(MAX_WORDS);

  state_t            state_q, state_d;
  logic [7:0]        len_hi_q, len_hi_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              in_ready_q, in_ready_d;
  logic              cpu_run_q, cpu_run_d;
  logic              load_err_q, load_err_d;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic              fire;
  logic              hi_en;
  logic              lo_en;
  logic [15:0]       len_word;
  logic [ADDR_W:0]   count_inc;

  assign fire      = in_valid && in_ready_q;
  assign len_word  = {len_hi_q, in_data};
  assign count_inc = count_q + CNT_ONE;

  // Next-state logic: walk length bytes, then data pairs, then (optional) checksum
  always_comb begin
    state_d    = state_q;
    len_hi_d   = len_hi_q;
    len_d      = len_q;
    count_d    = count_q;
    addr_d     = addr_q;
    cpu_run_d  = cpu_run_q;
    load_err_d = load_err_q;
    hi_en      = 1'b0;
    lo_en      = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif

    case (state_q)
      LEN_HI: begin
        if (fire) begin
          len_hi_d = in_data;
          state_d  = LEN_LO;
        end
      end

      LEN_LO: begin
        if (fire) begin
          if (len_word > MAX_LEN) begin
            state_d    = ERROR;
            load_err_d = 1'b1;
          end else if (len_word == 16'd0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            state_d   = CHK;
`else
            state_d   = DONE;
            cpu_run_d = 1'b1;
`endif
          end else begin
            // Fits in ADDR_W+1 bits because it is at most MAX_WORDS
            len_d   = len_word[ADDR_W:0];
            state_d = DATA_HI;
          end
        end
      end

      DATA_HI: begin
        if (fire) begin
          hi_en   = 1'b1;
          state_d = DATA_LO;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d  = csum_q ^ in_data;
`endif
        end
      end

      DATA_LO: begin
        if (fire) begin
          // Strobe, address and count all become visible on the next cycle
          lo_en   = 1'b1;
          addr_d  = count_q[ADDR_W-1:0];
          count_d = count_inc;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d  = csum_q ^ in_data;
`endif
          if (count_inc == len_q) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            state_d   = CHK;
`else
            state_d   = DONE;
            cpu_run_d = 1'b1;
`endif
          end else begin
            state_d = DATA_HI;
          end
        end
      end

`ifdef PROG_LOADER_CHECKSUM_EN
      CHK: begin
        if (fire) begin
          if (in_data == csum_q) begin
            state_d   = DONE;
            cpu_run_d = 1'b1;
          end else begin
            state_d    = ERROR;
            load_err_d = 1'b1;
          end
        end
      end
`endif

      DONE:    state_d = DONE;
      ERROR:   state_d = ERROR;
      default: state_d = ERROR;
    endcase

    in_ready_d = accepts_bytes(state_d);
  end

  // State and registered outputs; reset abandons any load in progress
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= LEN_HI;
      len_hi_q   <= 8'h00;
      len_q      <= '0;
      count_q    <= '0;
      addr_q     <= '0;
      in_ready_q <= 1'b0;
      cpu_run_q  <= 1'b0;
      load_err_q <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q     <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      len_hi_q   <= len_hi_d;
      len_q      <= len_d;
      count_q    <= count_d;
      addr_q     <= addr_d;
      in_ready_q <= in_ready_d;
      cpu_run_q  <= cpu_run_d;
      load_err_q <= load_err_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  byte_pair_asm u_asm (
    .clock      (clock),
    .reset_n    (reset_n),
    .hi_en      (hi_en),
    .lo_en      (lo_en),
    .byte_in    (in_data),
    .word_out   (imem_wdata),
    .word_valid (imem_we)
  );

  assign in_ready     = in_ready_q;
  assign imem_addr    = addr_q;
  assign cpu_run      = cpu_run_q;
  assign load_err     = load_err_q;
  assign words_loaded = count_q;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_loader
// Description : Directed self-checking bench for prog_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader;
  import prog_loader_pkg::*;

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam bit CSUM_BUILD = 1'b1;
`else
  localparam bit CSUM_BUILD = 1'b0;
`endif

  logic              clock    = 1'b0;
  logic              reset_n  = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data  = 8'h00;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;
  logic              cpu_run;
  logic              load_err;
  logic [ADDR_W:0]   words_loaded;

  int n_checks = 0;
  int n_errors = 0;

  logic [ADDR_W-1:0] log_addr[$];
  logic [15:0]       log_data[$];
  logic              log_run[$];

  logic [7:0]  prog3 [8]     = '{8'h00, 8'h03, 8'h51, 8'h00, 8'h52, 8'h04, 8'h73, 8'hC0};
  logic [15:0] exp_words [3] = '{16'h5100, 16'h5204, 16'h73C0};
  // 51^00^52^04^73^C0
  logic [7:0]  prog3_csum    = 8'hB4;

  always #5 clock = ~clock;

  prog_loader dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_run      (cpu_run),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  // Write log, sampled mid-cycle
  always @(negedge clock) begin
    if (imem_we === 1'b1) begin
      log_addr.push_back(imem_addr);
      log_data.push_back(imem_wdata);
      log_run.push_back(cpu_run);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    log_run.delete();
  endtask

  // Called at a negedge; returns at the negedge after the transfer edge
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (n >= 20) begin
      n_checks++;
      n_errors++;
      $error("FAIL send_timeout: observed in_ready=%b expected 1", in_ready);
    end
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n  = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clock);
    clear_log();
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic send_prog3(input bit gaps);
    for (int i = 0; i < 8; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) @(negedge clock);
      send_byte(prog3[i]);
    end
    if (CSUM_BUILD) send_byte(prog3_csum);
    repeat (3) @(negedge clock);
  endtask

  task automatic check_prog3(input string pfx);
    check({pfx, "_nwr"}, log_addr.size(), 3);
    for (int i = 0; i < 3 && i < log_addr.size(); i++) begin
      check($sformatf("%s_addr%0d", pfx, i), log_addr[i], i);
      check($sformatf("%s_data%0d", pfx, i), log_data[i], exp_words[i]);
    end
    check({pfx, "_words"}, words_loaded, 3);
    check({pfx, "_run"},   cpu_run, 1);
    check({pfx, "_err"},   load_err, 0);
    check({pfx, "_rdy"},   in_ready, 0);
  endtask

  initial begin
    // ---------------- reset state ----------------
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_ready", in_ready, 0);
    check("rst_we",    imem_we, 0);
    check("rst_addr",  imem_addr, 0);
    check("rst_wdata", imem_wdata, 0);
    check("rst_run",   cpu_run, 0);
    check("rst_err",   load_err, 0);
    check("rst_words", words_loaded, 0);
    reset_n = 1'b1;
    @(negedge clock);
    check("rst_ready_after", in_ready, 1);

    // ---------------- 3-word load, no gaps ----------------
    clear_log();
    send_prog3(1'b0);
    check_prog3("a");
    check("a_run_w0", (log_run.size() > 0) ? log_run[0] : 1'bx, 0);
    check("a_run_w2", (log_run.size() > 2) ? log_run[2] : 1'bx, !CSUM_BUILD);
    // bytes offered in DONE are ignored
    in_valid = 1'b1;
    in_data  = 8'hAA;
    repeat (4) @(negedge clock);
    in_valid = 1'b0;
    check("a_done_nwr",   log_addr.size(), 3);
    check("a_done_words", words_loaded, 3);

    // ---------------- same load with random gaps ----------------
    do_reset();
    send_prog3(1'b1);
    check_prog3("b");

    // ---------------- zero-length program ----------------
    do_reset();
    send_byte(8'h00);
    check("c_run_after_b0", cpu_run, 0);
    send_byte(8'h00);
    check("c_run_after_b1", cpu_run, !CSUM_BUILD);
    if (CSUM_BUILD) send_byte(8'h00);
    repeat (2) @(negedge clock);
    check("c_run",   cpu_run, 1);
    check("c_nwr",   log_addr.size(), 0);
    check("c_words", words_loaded, 0);
    check("c_rdy",   in_ready, 0);

    // ---------------- oversize length 1025 ----------------
    do_reset();
    send_byte(8'h04);
    send_byte(8'h01);
    check("d_err", load_err, 1);
    check("d_rdy", in_ready, 0);
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (4) @(negedge clock);
    in_valid = 1'b0;
    check("d_nwr",   log_addr.size(), 0);
    check("d_words", words_loaded, 0);
    check("d_run",   cpu_run, 0);
    check("d_err2",  load_err, 1);

`ifdef PROG_LOADER_CHECKSUM_EN
    // ---------------- checksum match ----------------
    do_reset();
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h12); send_byte(8'h34);
    check("e_run_pre", cpu_run, 0);
    send_byte(8'h26);
    check("e_run", cpu_run, 1);
    check("e_err", load_err, 0);
    check("e_nwr", log_addr.size(), 1);
    check("e_w0",  (log_data.size() > 0) ? log_data[0] : 16'hxxxx, 16'h1234);

    // ---------------- checksum mismatch ----------------
    do_reset();
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h12); send_byte(8'h34);
    send_byte(8'h27);
    check("f_err", load_err, 1);
    check("f_run", cpu_run, 0);
    check("f_rdy", in_ready, 0);
    check("f_nwr", log_addr.size(), 1);
    check("f_w0",  (log_data.size() > 0) ? log_data[0] : 16'hxxxx, 16'h1234);
`endif

    // ---------------- reset mid-load, then full reload ----------------
    do_reset();
    for (int i = 0; i < 5; i++) send_byte(prog3[i]);  // word 0 written, hi of word 1 taken
    check("g_nwr_pre",   log_addr.size(), 1);
    check("g_words_pre", words_loaded, 1);
    // offer the low byte of word 1 in the same cycle reset is asserted
    in_valid = 1'b1;
    in_data  = prog3[5];
    reset_n  = 1'b0;
    @(negedge clock);
    check("g_rst_we",    imem_we, 0);
    check("g_rst_run",   cpu_run, 0);
    check("g_rst_words", words_loaded, 0);
    check("g_rst_nwr",   log_addr.size(), 1);
    in_valid = 1'b0;
    @(negedge clock);
    clear_log();
    reset_n = 1'b1;
    @(negedge clock);
    send_prog3(1'b0);
    check_prog3("g");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
